// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: column-multiplexed scan, per-key debounce, hex encode,
// and a 16-bit shift register of accepted codes (newest nibble in [3:0]).
module keypad_scanner #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  row,
    input  logic        clear,
    output logic [3:0]  col,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [15:0] data
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_TICKS - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

    state_t            state_q;
    logic [3:0]        row_meta_q, rs_q;
    logic [DIV_W-1:0]  div_q;
    logic [DEB_W-1:0]  deb_q;
    logic [1:0]        r_q, c_q;
    logic [3:0]        col_q;
    logic              key_valid_q;
    logic [3:0]        key_code_q;
    logic [15:0]       data_q;

    logic              tick;
    logic [1:0]        col_idx, row_idx;
    logic [3:0]        col_rot, acc_code;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;  4'h2: key_map = 4'h3;  4'h3: key_map = 4'hA;
            4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h6;  4'h7: key_map = 4'hB;
            4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;  4'hA: key_map = 4'h9;  4'hB: key_map = 4'hC;
            4'hC: key_map = 4'h0;  4'hD: key_map = 4'hF;  4'hE: key_map = 4'hE;  default: key_map = 4'hD;
        endcase
    endfunction

    assign tick     = (div_q == DIV_LAST);
    assign col_rot  = {col_q[2:0], col_q[3]};
    assign acc_code = key_map(r_q, c_q);

    // Lowest-index low bit wins, so row 0 has priority on multi-key presses.
    always_comb begin
        col_idx = 2'd0;
        row_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!col_q[i]) col_idx = 2'(i);
            if (!rs_q[i])  row_idx = 2'(i);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_meta_q <= 4'hF;
            rs_q       <= 4'hF;
        end else begin
            row_meta_q <= row;
            rs_q       <= row_meta_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= SCAN;
            div_q       <= '0;
            deb_q       <= '0;
            r_q         <= 2'd0;
            c_q         <= 2'd0;
            col_q       <= 4'b1110;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            data_q      <= 16'h0000;
        end else begin
            key_valid_q <= 1'b0;
            div_q       <= tick ? '0 : div_q + 1'b1;
            if (clear) data_q <= 16'h0000;
            if (tick) begin
                case (state_q)
                    SCAN: begin
                        if (rs_q == 4'hF) begin
                            col_q <= col_rot;
                        end else begin
                            r_q     <= row_idx;
                            c_q     <= col_idx;
                            deb_q   <= DEB_W'(1);
                            state_q <= DEBOUNCE;
                        end
                    end
                    DEBOUNCE: begin
                        if (rs_q[r_q]) begin
                            state_q <= SCAN;
                            col_q   <= col_rot;
                        end else if (deb_q == DEB_LAST) begin
                            // Accept; a coincident clear still keeps the new code.
                            key_valid_q <= 1'b1;
                            key_code_q  <= acc_code;
                            data_q      <= clear ? {12'h000, acc_code} : {data_q[11:0], acc_code};
                            deb_q       <= '0;
                            state_q     <= HELD;
                        end else begin
                            deb_q <= deb_q + 1'b1;
                        end
                    end
                    HELD: begin
                        if (!rs_q[r_q]) begin
                            deb_q <= '0;
                        end else if (deb_q == DEB_LAST) begin
                            deb_q   <= '0;
                            state_q <= SCAN;
                            col_q   <= col_rot;
                        end else begin
                            deb_q <= deb_q + 1'b1;
                        end
                    end
                    default: state_q <= SCAN;
                endcase
            end
        end
    end

    assign col       = col_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign data      = data_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad model drives rows from col, expected
// accepts are queued at stimulus time and popped by a monitor on every key_valid.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DT = 3;

    logic        clk = 1'b0;
    logic        reset, clear;
    logic [3:0]  row, col, key_code;
    logic        key_valid;
    logic [15:0] data;

    always #5 clk = ~clk;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_TICKS(DT)) dut (
        .clk(clk), .reset(reset), .row(row), .clear(clear),
        .col(col), .key_valid(key_valid), .key_code(key_code), .data(data)
    );

    logic [3:0] kmap [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                                '{4'h4, 4'h5, 4'h6, 4'hB},
                                '{4'h7, 4'h8, 4'h9, 4'hC},
                                '{4'h0, 4'hF, 4'hE, 4'hD}};

    // Keypad: a pressed key pulls its row low while its column is driven low.
    bit ken [2];
    int kr [2];
    int kc [2];
    always_comb begin
        row = 4'hF;
        for (int k = 0; k < 2; k++)
            if (ken[k] && col[kc[k]] == 1'b0) row[kr[k]] = 1'b0;
    end

    typedef struct packed {logic [3:0] code; logic [15:0] data;} exp_t;
    exp_t        sbq [$];
    exp_t        got_e, push_e;
    logic [15:0] model_data = 16'h0;
    int          cmp = 0, err = 0;
    logic        kv_prev = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            cmp++;
            if (key_valid !== 1'b0) begin
                err++;
                $display("FAIL kv_in_reset: key_valid=%b, required 0", key_valid);
            end
        end
        if (key_valid && kv_prev) begin
            cmp++; err++;
            $display("FAIL kv_back_to_back: key_valid high two cycles, required single pulse");
        end
        if (key_valid === 1'b1) begin
            cmp++;
            if (sbq.size() == 0) begin
                err++;
                $display("FAIL unexpected_pulse: code=%h data=%h, required no pulse", key_code, data);
            end else begin
                got_e = sbq.pop_front();
                if (key_code !== got_e.code || data !== got_e.data) begin
                    err++;
                    $display("FAIL accept: code=%h data=%h, required code=%h data=%h",
                             key_code, data, got_e.code, got_e.data);
                end
            end
        end
        kv_prev = key_valid;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        cmp++;
        if (got !== req) begin
            err++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    task automatic press(input int idx, input logic [3:0] code);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (kmap[r][c] == code) begin
                    kr[idx] = r;
                    kc[idx] = c;
                end
        ken[idx] = 1'b1;
    endtask

    task automatic expect_accept(input logic [3:0] code, input bit cleared);
        model_data  = cleared ? {12'h000, code} : ((model_data << 4) | {12'h000, code});
        push_e.code = code;
        push_e.data = model_data;
        sbq.push_back(push_e);
    endtask

    // Clean press: held far longer than worst-case accept latency, gap longer than release debounce.
    task automatic hold_key(input logic [3:0] code, input int hold, input int gap, input bit second);
        expect_accept(code, 1'b0);
        press(0, code);
        if (second) begin
            cyc(40);
            press(1, 4'($urandom_range(0, 15)));
            cyc(hold - 40);
        end else begin
            cyc(hold);
        end
        ken[0] = 1'b0;
        ken[1] = 1'b0;
        cyc(gap);
    endtask

    // Returns just after the first edge at which col equals v.
    task automatic wait_col(input logic [3:0] v);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            cyc(1);
            if (col === v) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            cmp++; err++;
            $display("FAIL wait_col_timeout: col=%b, required %b", col, v);
        end
    endtask

    logic [3:0] ecol;
    initial begin
        reset = 1'b1; clear = 1'b0;
        ken[0] = 1'b0; ken[1] = 1'b0;
        kr[0] = 0; kc[0] = 0; kr[1] = 0; kc[1] = 0;
        cyc(2);
        check("rst_col", 32'(col), 32'h0E);
        check("rst_kv", 32'(key_valid), 32'h0);
        check("rst_code", 32'(key_code), 32'h0);
        check("rst_data", 32'(data), 32'h0);
        reset = 1'b0;

        // Idle scan: col rotates left every SD cycles.
        for (int n = 1; n <= 200; n++) begin
            cyc(1);
            ecol = 4'b1110;
            for (int j = 0; j < (n / SD) % 4; j++) ecol = {ecol[2:0], ecol[3]};
            check("idle_col", 32'(col), 32'(ecol));
        end
        check("idle_data", 32'(data), 32'h0);

        hold_key(4'h5, 100, 60, 1'b0);
        check("single_data", 32'(data), 32'h0005);
        check("single_code", 32'(key_code), 32'h5);

        hold_key(4'h1, 70, 60, 1'b0);
        hold_key(4'hA, 70, 60, 1'b0);
        hold_key(4'h0, 70, 60, 1'b0);
        hold_key(4'hD, 70, 60, 1'b0);
        check("seq_data_d", 32'(data), 32'h1A0D);
        hold_key(4'hE, 70, 60, 1'b0);
        check("seq_data_e", 32'(data), 32'hA0DE);
        check("seq_code", 32'(key_code), 32'hE);

        // Bouncy "9": never three consecutive low ticks, so nothing is accepted.
        press(0, 4'h9);
        for (int i = 0; i < 13; i++) begin
            cyc(3);
            ken[0] = ~ken[0];
        end
        cyc(60);
        hold_key(4'h9, 80, 60, 1'b0);
        check("bounce_code", 32'(key_code), 32'h9);

        for (int i = 0; i < 8; i++) begin
            hold_key(4'($urandom_range(0, 15)), $urandom_range(50, 100),
                     $urandom_range(40, 70), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                clear = 1'b1;
                cyc(1);
                clear = 1'b0;
                model_data = 16'h0;
                check("rand_clear", 32'(data), 32'h0);
                cyc(10);
            end
        end

        hold_key(4'h1, 60, 50, 1'b0);
        hold_key(4'h2, 60, 50, 1'b0);
        hold_key(4'h3, 60, 50, 1'b0);
        hold_key(4'h4, 60, 50, 1'b0);
        check("preload", 32'(data), 32'h1234);

        // "B" (col 3): detect one tick after col reaches 0111, accept two ticks later.
        wait_col(4'b1110);
        press(0, 4'hB);
        wait_col(4'b0111);
        expect_accept(4'hB, 1'b1);
        cyc(SD * DT - 1);
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        cyc(40);
        ken[0] = 1'b0;
        cyc(60);
        check("collide_data", 32'(data), 32'h000B);

        // "F" (col 1): reset lands just after the second debounce tick.
        wait_col(4'b1110);
        press(0, 4'hF);
        wait_col(4'b1101);
        cyc(2 * SD + 1);
        reset = 1'b1;
        cyc(1);
        check("midrst_col", 32'(col), 32'h0E);
        check("midrst_kv", 32'(key_valid), 32'h0);
        check("midrst_code", 32'(key_code), 32'h0);
        check("midrst_data", 32'(data), 32'h0);
        cyc(3);
        model_data = 16'h0;
        expect_accept(4'hF, 1'b0);
        reset = 1'b0;
        cyc(80);
        ken[0] = 1'b0;
        cyc(60);
        check("post_rst_data", 32'(data), 32'h000F);

        cyc(20);
        check("sb_empty", 32'(sbq.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end

endmodule
